// File: rtl/nlm_cu_sched.sv
// nlm_cu_sched
// Frame-synchronous scheduler for the NLM compute unit (CU). It watches the
// packed sensor parameter registers and launches one CU task at a frame start
// when the parameters have changed, or when an update has been forced. The
// task end is awaited under a timeout, and the six results are staged. The
// staged set is committed to frame-stable outputs at the following frame
// start, so downstream NLM logic never sees a mid-frame update.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   i_frm_start  one-cycle frame-start pulse
//   i_force_upd  one-cycle request to recompute with unchanged parameters
//   i_parm_bus   packed live sensor parameters (PARM_SZ bits)
//   i_cu_tsk_end CU end-of-task pulse
//   i_cu_op      six CU results, op0 in the lowest ALU_SZ bits
//   o_cu_tsk_trg one-cycle task trigger to the CU
//   o_op         committed, frame-stable results
//   o_op_vld     high once any result set has been committed
//   o_upd_pls    one-cycle pulse in the cycle o_op changes
//   o_busy       high while a task is being triggered or awaited
//   o_tmo_err    sticky timeout flag, cleared by the next successful task
module nlm_cu_sched #(
  parameter int ALU_SZ  = 16,
  parameter int PARM_SZ = 64,
  parameter int TMO_CYC = 64,
  parameter int TMO_WID = $clog2(TMO_CYC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_frm_start,
  input  logic                i_force_upd,
  input  logic [PARM_SZ-1:0]  i_parm_bus,
  input  logic                i_cu_tsk_end,
  input  logic [6*ALU_SZ-1:0] i_cu_op,
  output logic                o_cu_tsk_trg,
  output logic [6*ALU_SZ-1:0] o_op,
  output logic                o_op_vld,
  output logic                o_upd_pls,
  output logic                o_busy,
  output logic                o_tmo_err
);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_t;

  localparam logic [TMO_WID-1:0] TMO_LAST = TMO_WID'(TMO_CYC - 1);

  state_t              state;
  state_t              state_n;
  logic [PARM_SZ-1:0]  snap;
  logic                force_flg;
  logic                stg_vld;
  logic [6*ALU_SZ-1:0] staging;
  logic [TMO_WID-1:0]  counter;

  logic pending;
  logic commit;
  logic launch;
  logic tsk_done;
  logic tmo_hit;

  // A task is owed whenever the live parameters differ from the set the last
  // task was launched with, or a recompute has been requested.
  assign pending = (i_parm_bus != snap) || force_flg;

  // Commit only looks at the staging flag, not at the FSM, so a commit and a
  // new launch can share the same frame start.
  assign commit = i_frm_start && stg_vld;

  // Next-state logic and the single-cycle event strobes used by the datapath.
  always_comb begin
    state_n  = state;
    launch   = 1'b0;
    tsk_done = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (i_frm_start && pending) begin
          launch  = 1'b1;
          state_n = TRIG;
        end
      end
      TRIG: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (i_cu_tsk_end) begin
          tsk_done = 1'b1;
          state_n  = IDLE;
        end else if (counter == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs, parameter snapshot, staging buffer and timeout
  // counter. Later assignments deliberately override earlier ones: a task end
  // coinciding with a commit leaves the fresh set staged, and a force request
  // coinciding with a launch keeps the force flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cu_tsk_trg <= 1'b0;
      o_op         <= '0;
      o_op_vld     <= 1'b0;
      o_upd_pls    <= 1'b0;
      o_busy       <= 1'b0;
      o_tmo_err    <= 1'b0;
      snap         <= '0;
      force_flg    <= 1'b1;
      stg_vld      <= 1'b0;
      staging      <= '0;
      counter      <= '0;
    end else begin
      o_cu_tsk_trg <= launch;
      o_busy       <= (state_n != IDLE);
      o_upd_pls    <= commit;

      if (launch) begin
        snap <= i_parm_bus;
      end

      if (state == TRIG) begin
        counter <= '0;
      end else if (state == WAIT && !tsk_done && !tmo_hit) begin
        counter <= counter + 1'b1;
      end

      if (commit) begin
        o_op     <= staging;
        o_op_vld <= 1'b1;
        stg_vld  <= 1'b0;
      end

      if (tsk_done) begin
        staging   <= i_cu_op;
        stg_vld   <= 1'b1;
        o_tmo_err <= 1'b0;
      end

      // A timed-out task leaves the snapshot as launched, so the force flag
      // is what makes the next frame start retry.
      if (tmo_hit) begin
        o_tmo_err <= 1'b1;
      end

      if (launch) begin
        force_flg <= 1'b0;
      end
      if (tmo_hit || i_force_upd) begin
        force_flg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nlm_cu_sched.sv
// tb_nlm_cu_sched
// Directed bench for nlm_cu_sched. Stimulus pushes the cycle of each expected
// trigger and the cycle plus value of each expected commit into queues; a
// monitor on the falling edge pops and compares whenever the DUT raises
// o_cu_tsk_trg or o_upd_pls. A few level checks (busy, timeout, reset values)
// are made directly from the stimulus.
module tb_nlm_cu_sched;

  localparam int ALU_SZ  = 16;
  localparam int PARM_SZ = 64;
  localparam int TMO_CYC = 16;
  localparam int OPW     = 6 * ALU_SZ;

  localparam logic [PARM_SZ-1:0] P0 = {16'd3, 48'h1111_2222_3333};
  localparam logic [PARM_SZ-1:0] P1 = {16'd7, 48'h1111_2222_3333};
  localparam logic [OPW-1:0] OP_A = {16'hBEEF, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h0123};
  localparam logic [OPW-1:0] OP_B = {16'h1234, 16'hA5A5, 16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE};
  localparam logic [OPW-1:0] OP_C = {16'hDEAD, 16'hCAFE, 16'h0BAD, 16'hF00D, 16'h1111, 16'h9999};

  logic               clk = 1'b0;
  logic               rst;
  logic               i_frm_start;
  logic               i_force_upd;
  logic [PARM_SZ-1:0] i_parm_bus;
  logic               i_cu_tsk_end;
  logic [OPW-1:0]     i_cu_op;
  logic               o_cu_tsk_trg;
  logic [OPW-1:0]     o_op;
  logic               o_op_vld;
  logic               o_upd_pls;
  logic               o_busy;
  logic               o_tmo_err;

  typedef struct {
    int             cyc;
    logic [OPW-1:0] op;
  } commit_t;

  int      trig_q[$];
  commit_t commit_q[$];
  int      cyc    = 0;
  int      checks = 0;
  int      errors = 0;

  nlm_cu_sched #(
    .ALU_SZ (ALU_SZ),
    .PARM_SZ(PARM_SZ),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_frm_start (i_frm_start),
    .i_force_upd (i_force_upd),
    .i_parm_bus  (i_parm_bus),
    .i_cu_tsk_end(i_cu_tsk_end),
    .i_cu_op     (i_cu_op),
    .o_cu_tsk_trg(o_cu_tsk_trg),
    .o_op        (o_op),
    .o_op_vld    (o_op_vld),
    .o_upd_pls   (o_upd_pls),
    .o_busy      (o_busy),
    .o_tmo_err   (o_tmo_err)
  );

  // Free-running clock and a cycle index readable on the falling edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [OPW-1:0] act,
                             input logic [OPW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of pulse inputs at a falling edge and returns on the
  // next falling edge with the pulses cleared.
  task automatic applyStimulus(input logic frm, input logic frc, input logic tend);
    i_frm_start  = frm;
    i_force_upd  = frc;
    i_cu_tsk_end = tend;
    @(negedge clk);
    i_frm_start  = 1'b0;
    i_force_upd  = 1'b0;
    i_cu_tsk_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expectCommit(input int c, input logic [OPW-1:0] op);
    commit_t e;
    e.cyc = c;
    e.op  = op;
    commit_q.push_back(e);
  endtask

  // Monitor: every trigger and every update pulse must match the head of its
  // expectation queue.
  always @(negedge clk) begin
    if (o_cu_tsk_trg) begin
      if (trig_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL trig_unexpected: trigger at cycle %0d, none expected", cyc);
      end else begin
        checkOutput("trig_cycle", OPW'(cyc), OPW'(trig_q.pop_front()));
      end
    end
    if (o_upd_pls) begin
      if (commit_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL commit_unexpected: update pulse at cycle %0d, none expected", cyc);
      end else begin
        commit_t e;
        e = commit_q.pop_front();
        checkOutput("commit_cycle", OPW'(cyc), OPW'(e.cyc));
        checkOutput("commit_op", o_op, e.op);
        checkOutput("commit_vld", OPW'(o_op_vld), OPW'(1));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    i_frm_start  = 1'b0;
    i_force_upd  = 1'b0;
    i_cu_tsk_end = 1'b0;
    i_parm_bus   = P0;
    i_cu_op      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_trg", OPW'(o_cu_tsk_trg), '0);
    checkOutput("rst_op", o_op, '0);
    checkOutput("rst_vld", OPW'(o_op_vld), '0);
    checkOutput("rst_upd", OPW'(o_upd_pls), '0);
    checkOutput("rst_busy", OPW'(o_busy), '0);
    checkOutput("rst_tmo", OPW'(o_tmo_err), '0);
    idle(5);

    $display("[TB] first frame computes, commit at following frame start");
    trig_q.push_back(cyc + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_busy_trig", OPW'(o_busy), OPW'(1));
    idle(3);
    checkOutput("t1_busy_wait", OPW'(o_busy), OPW'(1));
    idle(1);
    i_cu_op = OP_A;
    checkOutput("t1_busy_end", OPW'(o_busy), OPW'(1));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_busy_done", OPW'(o_busy), OPW'(0));
    checkOutput("t1_vld_before", OPW'(o_op_vld), OPW'(0));
    idle(10);
    expectCommit(cyc + 1, OP_A);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_op", o_op, OP_A);

    $display("[TB] unchanged parameters do not relaunch");
    repeat (2) begin
      idle(8);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    idle(2);
    checkOutput("t2_op_stable", o_op, OP_A);
    checkOutput("t2_vld", OPW'(o_op_vld), OPW'(1));

    $display("[TB] forced update with identical results");
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle(4);
    trig_q.push_back(cyc + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(5);
    expectCommit(cyc + 1, OP_A);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(3);

    $display("[TB] timeout and retry");
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle(2);
    trig_q.push_back(cyc + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(TMO_CYC);
    checkOutput("t4_tmo_last_wait", OPW'(o_tmo_err), OPW'(0));
    checkOutput("t4_busy_last_wait", OPW'(o_busy), OPW'(1));
    idle(1);
    checkOutput("t4_tmo_set", OPW'(o_tmo_err), OPW'(1));
    checkOutput("t4_busy_after_tmo", OPW'(o_busy), OPW'(0));
    idle(3);
    trig_q.push_back(cyc + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2);

    $display("[TB] parameter change during wait");
    i_parm_bus = P1;
    idle(2);
    i_cu_op = OP_B;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_tmo_cleared", OPW'(o_tmo_err), OPW'(0));
    idle(4);
    trig_q.push_back(cyc + 1);
    expectCommit(cyc + 1, OP_B);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_op", o_op, OP_B);
    idle(1);

    $display("[TB] reset during wait with late end pulse");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst     = 1'b0;
    i_cu_op = OP_C;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_trg", OPW'(o_cu_tsk_trg), '0);
    checkOutput("t6_op", o_op, '0);
    checkOutput("t6_vld", OPW'(o_op_vld), '0);
    checkOutput("t6_upd", OPW'(o_upd_pls), '0);
    checkOutput("t6_busy", OPW'(o_busy), '0);
    checkOutput("t6_tmo", OPW'(o_tmo_err), '0);
    idle(3);
    trig_q.push_back(cyc + 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(3);
    checkOutput("t6_op_still_zero", o_op, '0);
    checkOutput("t6_vld_still_zero", OPW'(o_op_vld), '0);

    checkOutput("trig_q_drained", OPW'(trig_q.size()), '0);
    checkOutput("commit_q_drained", OPW'(commit_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
